example_axil_master: RTL and testbench
======================================

// Module: example_axil_master
// PURPOSE: AXI4-Lite initiator; converts a single-entry valid/ready command stream into AXI4-Lite reads/writes and returns one response per command.
//   Drives the slave side of the GP0-style control register block from PL logic (self-test/bring-up); one transaction outstanding at a time.
// PARAMETERS:
//   C_M_AXI_ADDR_WIDTH  10  AXI and command address width
//   C_M_AXI_DATA_WIDTH  32  AXI and command data width; only 32 supported
//   TIMEOUT_CYCLES      1024  watchdog limit in cycles; used only when EXAMPLE_AXIL_MASTER_WATCHDOG_EN is defined
// PORTS:
//   aclk             in   1       clock
//   aresetn          in   1       asynchronous active-low reset
//   cmd_v_i          in   1       command valid
//   cmd_ready_o      out  1       command ready (high only in IDLE)
//   cmd_we_i         in   1       1=write, 0=read
//   cmd_addr_i       in   ADDR    byte address
//   cmd_data_i       in   DATA    write data (ignored for reads)
//   resp_v_o         out  1       response valid
//   resp_yumi_i      in   1       response consumed; legal only while resp_v_o=1
//   resp_data_o      out  DATA    read data; 0 for writes
//   resp_err_o       out  1       1 if BRESP/RRESP != OKAY
//   timeout_o        out  1       sticky watchdog flag
//   m_axi_awaddr     out  ADDR    write address
//   m_axi_awprot     out  3       constant 3'b000
//   m_axi_awvalid    out  1       write address valid
//   m_axi_awready    in   1       write address ready
//   m_axi_wdata      out  DATA    write data
//   m_axi_wstrb      out  DATA/8  constant all ones
//   m_axi_wvalid     out  1       write data valid
//   m_axi_wready     in   1       write data ready
//   m_axi_bresp      in   2       write response
//   m_axi_bvalid     in   1       write response valid
//   m_axi_bready     out  1       write response ready
//   m_axi_araddr     out  ADDR    read address
//   m_axi_arprot     out  3       constant 3'b000
//   m_axi_arvalid    out  1       read address valid
//   m_axi_arready    in   1       read address ready
//   m_axi_rdata      in   DATA    read data
//   m_axi_rresp      in   2       read response
//   m_axi_rvalid     in   1       read data valid
//   m_axi_rready     out  1       read data ready
// BEHAVIOUR:
// - FSM states IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE. On reset: IDLE; every valid/ready output, resp_data_o, resp_err_o and timeout_o = 0; cmd_ready_o = 1.
// - IDLE: cmd_v_i & cmd_ready_o latches addr/data/we into registers; next state WR_REQ (we=1) or RD_REQ. AW/W/AR valid rise one cycle after acceptance.
// - WR_REQ: awvalid and wvalid asserted together; each drops the cycle after its own handshake (aw_done/w_done flags). AW first, W first and same-cycle completion are all legal. Both done -> WR_RESP.
// - WR_RESP: bready=1; on bvalid: resp_err_o=(bresp!=0), resp_data_o=0 -> DONE. RD_REQ: arvalid until arready -> RD_RESP. RD_RESP: rready=1; on rvalid: capture rdata, rresp -> DONE.
// - DONE: resp_v_o=1 with data/err held stable until resp_yumi_i, then IDLE. Minimum latency with zero-wait slave: cmd accept to resp_v_o = 3 cycles (read), 3 cycles (write).
// - Valid outputs never drop before their handshake; address/data stable while valid. bready/rready are low outside their states.
// - Reset asserted mid-transaction aborts immediately to reset values; no response is produced for the aborted command.
// CONFIGURATION:
// - EXAMPLE_AXIL_MASTER_WATCHDOG_EN defined: counter clears on every state change and increments in WR_REQ/WR_RESP/RD_REQ/RD_RESP; at TIMEOUT_CYCLES, timeout_o sets and stays 1 until reset. The transaction is not aborted.
// - Not defined: no counter logic; timeout_o tied 0.
// TESTING:
// 1. Write addr 0x10 data 0xDEADBEEF, zero-wait slave -> one AW+W beat (wstrb 4'hF); resp_v_o 3 cycles after accept; err=0, data=0.
// 2. Read addr 0x10 after (1) -> araddr 0x10; resp_data_o=0xDEADBEEF, err=0; cmd_ready_o low from accept until yumi.
// 3. Slave delays wready 5 cycles after awready, then reverses the order -> awvalid/wvalid each drop after own handshake; exactly one write reaches the slave per command.
// 4. Slave returns rresp=2'b10 -> resp_err_o=1; hold resp_yumi_i low 4 cycles -> resp_v_o/data stable, no new cmd accepted.
// 5. Deassert aresetn during RD_RESP -> all outputs reset asynchronously; next command runs normally.
// 6. WATCHDOG_EN, TIMEOUT_CYCLES=16, bvalid withheld -> timeout_o=1 on the 16th wait cycle; later bvalid completes the write normally; timeout_o stays 1.

Source files
------------

// File: rtl/example_axil_master.sv
// rtl/example_axil_master.sv - single-outstanding AXI4-Lite initiator driven by a valid/ready command stream
//
// Purpose: accepts one read/write command at a time, performs it on an
// AXI4-Lite master port and returns one response (read data / error flag).
// Optional watchdog: define EXAMPLE_AXIL_MASTER_WATCHDOG_EN to enable the
// sticky timeout_o flag; otherwise timeout_o is tied low.
//
// Ports:
//   aclk, aresetn                   clock, asynchronous active-low reset
//   cmd_v_i / cmd_ready_o           command handshake (ready only when idle)
//   cmd_we_i, cmd_addr_i, cmd_data_i command fields
//   resp_v_o / resp_yumi_i          response handshake
//   resp_data_o, resp_err_o         read data (0 for writes), slave error
//   timeout_o                       sticky watchdog flag
//   m_axi_aw*/w*/b*/ar*/r*          AXI4-Lite master channels
module example_axil_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 10,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES     = 1024
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic                            cmd_v_i,
    output logic                            cmd_ready_o,
    input  logic                            cmd_we_i,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_data_i,
    output logic                            resp_v_o,
    input  logic                            resp_yumi_i,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   resp_data_o,
    output logic                            resp_err_o,
    output logic                            timeout_o,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [2:0]                      m_axi_awprot,
    output logic                            m_axi_awvalid,
    input  logic                            m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                            m_axi_wvalid,
    input  logic                            m_axi_wready,
    input  logic [1:0]                      m_axi_bresp,
    input  logic                            m_axi_bvalid,
    output logic                            m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [2:0]                      m_axi_arprot,
    output logic                            m_axi_arvalid,
    input  logic                            m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                      m_axi_rresp,
    input  logic                            m_axi_rvalid,
    output logic                            m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                          state_q, state_d;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   data_q;
    logic                            aw_done_q, w_done_q;
    logic [C_M_AXI_DATA_WIDTH-1:0]   resp_data_q;
    logic                            resp_err_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_v_i) begin
                addr_q <= cmd_addr_i;
                data_q <= cmd_data_i;
            end
            // Per-channel completion flags let AW and W finish in any order.
            if (state_q == WR_REQ) begin
                if (m_axi_awvalid && m_axi_awready) aw_done_q <= 1'b1;
                if (m_axi_wvalid && m_axi_wready)   w_done_q  <= 1'b1;
            end else begin
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (state_q == WR_RESP && m_axi_bvalid) begin
                resp_data_q <= '0;
                resp_err_q  <= (m_axi_bresp != 2'b00);
            end
            if (state_q == RD_RESP && m_axi_rvalid) begin
                resp_data_q <= m_axi_rdata;
                resp_err_q  <= (m_axi_rresp != 2'b00);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cmd_ready_o   = 1'b0;
        resp_v_o      = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = 1'b1;
                if (cmd_v_i) state_d = cmd_we_i ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = !w_done_q;
                if ((aw_done_q || m_axi_awready) && (w_done_q || m_axi_wready))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) state_d = DONE;
            end
            RD_REQ: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) state_d = RD_RESP;
            end
            RD_RESP: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) state_d = DONE;
            end
            DONE: begin
                resp_v_o = 1'b1;
                if (resp_yumi_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_data_o  = resp_data_q;
    assign resp_err_o   = resp_err_q;
    assign m_axi_awaddr = addr_q;
    assign m_axi_araddr = addr_q;
    assign m_axi_wdata  = data_q;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = '1;

`ifdef EXAMPLE_AXIL_MASTER_WATCHDOG_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wd_cnt_q;
    logic          timeout_q;
    logic          in_wait;

    assign in_wait = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                     (state_q == RD_REQ) || (state_q == RD_RESP);

    // Counts cycles spent in one waiting state; the flag only reports a hung
    // slave, the transaction itself keeps waiting.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else if (state_d != state_q) begin
            wd_cnt_q <= '0;
        end else if (in_wait) begin
            if (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1)) timeout_q <= 1'b1;
            else                                      wd_cnt_q  <= wd_cnt_q + 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_example_axil_master.sv
// tb/tb_example_axil_master.sv - scoreboard bench for example_axil_master with a delay-configurable AXI4-Lite slave
module tb_example_axil_master;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_v, cmd_we, resp_yumi;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_ready_o, resp_v_o, resp_err_o, timeout_o;
    logic [31:0] resp_data_o;
    logic [9:0]  m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    example_axil_master #(
        .C_M_AXI_ADDR_WIDTH(10), .C_M_AXI_DATA_WIDTH(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
        .resp_v_o(resp_v_o), .resp_yumi_i(resp_yumi), .resp_data_o(resp_data_o),
        .resp_err_o(resp_err_o), .timeout_o(timeout_o),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
        .m_axi_awready(awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];

    logic [31:0] ref_mem [0:255];
    logic [31:0] smem    [0:255];
    int          acc_cyc;

    // slave configuration (written by the test thread)
    int   aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
    logic b_hold = 1'b0;
    logic [1:0] bresp_cfg = 2'b00, rresp_cfg = 2'b00;

    // slave observations
    int          aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0, proto_err = 0;
    logic [9:0]  got_awaddr, got_araddr;
    logic [2:0]  got_awprot, got_arprot;
    logic [31:0] got_wdata;
    logic [3:0]  got_wstrb;

    // AXI4-Lite slave: everything decided at the falling edge. A handshake
    // is booked when valid&ready are both high after this process updates
    // its outputs, and retired at the next falling edge.
    initial begin
        logic aw_bk, w_bk, b_bk, ar_bk, r_bk, wa_have, wd_have, b_due, rd_have;
        logic aw_wait, w_wait, ar_wait;
        logic [9:0]  wait_awaddr, wait_araddr;
        logic [31:0] wait_wdata;
        int awc, wc, bc, arc, rc;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_bk = 0; w_bk = 0; b_bk = 0; ar_bk = 0; r_bk = 0;
        wa_have = 0; wd_have = 0; b_due = 0; rd_have = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        wait_awaddr = 0; wait_araddr = 0; wait_wdata = 0;
        awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
                aw_bk = 0; w_bk = 0; b_bk = 0; ar_bk = 0; r_bk = 0;
                wa_have = 0; wd_have = 0; b_due = 0; rd_have = 0;
                aw_wait = 0; w_wait = 0; ar_wait = 0;
                awc = 0; wc = 0; bc = 0; arc = 0; rc = 0;
            end else begin
                if (aw_wait && (!m_axi_awvalid || m_axi_awaddr !== wait_awaddr)) proto_err++;
                if (w_wait && (!m_axi_wvalid || m_axi_wdata !== wait_wdata))    proto_err++;
                if (ar_wait && (!m_axi_arvalid || m_axi_araddr !== wait_araddr)) proto_err++;
                if (m_axi_bready && m_axi_rready) proto_err++;
                if ((m_axi_awvalid || m_axi_wvalid) && m_axi_arvalid) proto_err++;
                if (aw_bk) begin aw_bk = 0; awready = 0; aw_n++; wa_have = 1; awc = 0; end
                if (w_bk)  begin w_bk = 0;  wready = 0;  w_n++;  wd_have = 1; wc = 0;  end
                if (b_bk)  begin b_bk = 0;  bvalid = 0;  b_n++;  bc = 0; end
                if (ar_bk) begin ar_bk = 0; arready = 0; ar_n++; rd_have = 1; arc = 0; end
                if (r_bk)  begin r_bk = 0;  rvalid = 0;  r_n++;  rc = 0; end
                if (wa_have && wd_have) begin
                    smem[got_awaddr[9:2]] = got_wdata;
                    wa_have = 0; wd_have = 0; b_due = 1;
                end
                if (b_due && !bvalid && !b_hold) begin
                    if (bc >= b_delay) begin bvalid = 1; bresp = bresp_cfg; b_due = 0; end
                    else bc++;
                end
                if (rd_have && !rvalid) begin
                    if (rc >= r_delay) begin
                        rvalid = 1; rdata = smem[got_araddr[9:2]]; rresp = rresp_cfg; rd_have = 0;
                    end else rc++;
                end
                if (m_axi_awvalid && !awready) begin if (awc >= aw_delay) awready = 1; else awc++; end
                if (m_axi_wvalid && !wready)   begin if (wc >= w_delay)   wready = 1;  else wc++;  end
                if (m_axi_arvalid && !arready) begin if (arc >= ar_delay) arready = 1; else arc++; end
                if (m_axi_awvalid && awready) begin aw_bk = 1; got_awaddr = m_axi_awaddr; got_awprot = m_axi_awprot; end
                if (m_axi_wvalid && wready)   begin w_bk = 1; got_wdata = m_axi_wdata; got_wstrb = m_axi_wstrb; end
                if (bvalid && m_axi_bready)   b_bk = 1;
                if (m_axi_arvalid && arready) begin ar_bk = 1; got_araddr = m_axi_araddr; got_arprot = m_axi_arprot; end
                if (rvalid && m_axi_rready)   r_bk = 1;
                aw_wait = m_axi_awvalid && !awready; wait_awaddr = m_axi_awaddr;
                w_wait  = m_axi_wvalid && !wready;   wait_wdata  = m_axi_wdata;
                ar_wait = m_axi_arvalid && !arready; wait_araddr = m_axi_araddr;
            end
        end
    end

    task automatic issue(input logic we, input logic [9:0] addr, input logic [31:0] data);
        int n = 0;
        @(negedge aclk);
        cmd_v = 1; cmd_we = we; cmd_addr = addr; cmd_data = data;
        while (!cmd_ready_o && n < 100) begin @(negedge aclk); n++; end
        total++;
        if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL issue_accept ready=%b want=1", cmd_ready_o); end
        acc_cyc = cyc;
        if (we) begin
            ref_mem[addr[9:2]] = data;
            sb.push_back('{data: 32'h0, err: (bresp_cfg != 2'b00)});
        end else begin
            sb.push_back('{data: ref_mem[addr[9:2]], err: (rresp_cfg != 2'b00)});
        end
        @(negedge aclk);
        cmd_v = 0;
    endtask

    task automatic collect(input int hold, input int want_lat, input string tag);
        int n = 0;
        logic rdy_bad = 0, hold_bad = 0;
        logic [31:0] d0;
        logic e0;
        exp_t e;
        while (!resp_v_o && n < 200) begin
            if (cmd_ready_o) rdy_bad = 1;
            @(negedge aclk); n++;
        end
        total++;
        if (resp_v_o !== 1'b1) begin
            bad++; $display("FAIL %s_resp_timeout resp_v=%b want=1", tag, resp_v_o);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (want_lat >= 0) begin
            total++;
            if (cyc - acc_cyc != want_lat) begin
                bad++; $display("FAIL %s_latency got=%0d want=%0d", tag, cyc - acc_cyc, want_lat);
            end
        end
        total++;
        if (rdy_bad) begin bad++; $display("FAIL %s_cmd_ready_busy got=1 want=0", tag); end
        total++;
        if (sb.size() == 0) begin
            bad++; $display("FAIL %s_sb_empty size=0 want=1", tag);
        end else begin
            e = sb.pop_front();
            if (resp_data_o !== e.data || resp_err_o !== e.err) begin
                bad++; $display("FAIL %s_resp data=%h err=%b want data=%h err=%b",
                                tag, resp_data_o, resp_err_o, e.data, e.err);
            end
        end
        if (hold > 0) begin
            d0 = resp_data_o; e0 = resp_err_o;
            cmd_v = 1; cmd_we = 0; cmd_addr = 10'h3fc;
            repeat (hold) begin
                @(negedge aclk);
                if (resp_v_o !== 1'b1 || resp_data_o !== d0 || resp_err_o !== e0 || cmd_ready_o !== 1'b0)
                    hold_bad = 1;
            end
            cmd_v = 0;
            total++;
            if (hold_bad) begin bad++; $display("FAIL %s_hold_stable got=unstable want=stable", tag); end
        end
        resp_yumi = 1;
        @(negedge aclk);
        resp_yumi = 0;
        total++;
        if (resp_v_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
            bad++; $display("FAIL %s_after_yumi resp_v=%b ready=%b want 0 1", tag, resp_v_o, cmd_ready_o);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge aclk);
        total++;
        if ({cmd_ready_o, resp_v_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready} !== 7'b1000000) begin
            bad++; $display("FAIL reset_handshakes got=%b want=1000000",
                {cmd_ready_o, resp_v_o, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready});
        end
        total++;
        if (resp_data_o !== 32'h0 || resp_err_o !== 1'b0 || timeout_o !== 1'b0) begin
            bad++; $display("FAIL reset_resp data=%h err=%b to=%b want 0 0 0", resp_data_o, resp_err_o, timeout_o);
        end
        #2 aresetn = 1;
        @(negedge aclk);
        total++;
        if (cmd_ready_o !== 1'b1 || resp_v_o !== 1'b0) begin
            bad++; $display("FAIL reset_release ready=%b resp_v=%b want 1 0", cmd_ready_o, resp_v_o);
        end
    endtask

    task automatic test_write_zero_wait;
        int aw0 = aw_n, w0 = w_n;
        issue(1'b1, 10'h010, 32'hDEADBEEF);
        collect(0, 3, "wr0");
        total++;
        if (aw_n - aw0 != 1 || w_n - w0 != 1) begin
            bad++; $display("FAIL wr0_beats aw=%0d w=%0d want 1 1", aw_n - aw0, w_n - w0);
        end
        total++;
        if (got_awaddr !== 10'h010 || got_wdata !== 32'hDEADBEEF || got_wstrb !== 4'hF || got_awprot !== 3'b000) begin
            bad++; $display("FAIL wr0_fields addr=%h data=%h strb=%h prot=%b want 010 deadbeef f 000",
                            got_awaddr, got_wdata, got_wstrb, got_awprot);
        end
    endtask

    task automatic test_read_back;
        issue(1'b0, 10'h010, 32'h0);
        collect(0, 3, "rd0");
        total++;
        if (got_araddr !== 10'h010 || got_arprot !== 3'b000) begin
            bad++; $display("FAIL rd0_araddr got=%h prot=%b want 010 000", got_araddr, got_arprot);
        end
    endtask

    task automatic test_write_skew;
        int aw0, w0, p0;
        p0 = proto_err;
        aw_delay = 0; w_delay = 5; aw0 = aw_n; w0 = w_n;
        issue(1'b1, 10'h024, 32'h1234_5678);
        repeat (2) @(negedge aclk);
        total++;
        if (m_axi_awvalid !== 1'b0 || m_axi_wvalid !== 1'b1) begin
            bad++; $display("FAIL skew_aw_first awv=%b wv=%b want 0 1", m_axi_awvalid, m_axi_wvalid);
        end
        collect(0, -1, "skew1");
        aw_delay = 5; w_delay = 0;
        issue(1'b1, 10'h028, 32'h0BAD_F00D);
        repeat (2) @(negedge aclk);
        total++;
        if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b0) begin
            bad++; $display("FAIL skew_w_first awv=%b wv=%b want 1 0", m_axi_awvalid, m_axi_wvalid);
        end
        collect(0, -1, "skew2");
        aw_delay = 0; w_delay = 0;
        total++;
        if (aw_n - aw0 != 2 || w_n - w0 != 2) begin
            bad++; $display("FAIL skew_beats aw=%0d w=%0d want 2 2", aw_n - aw0, w_n - w0);
        end
        total++;
        if (proto_err != p0) begin bad++; $display("FAIL skew_protocol got=%0d want=%0d", proto_err, p0); end
        issue(1'b0, 10'h024, 32'h0);
        collect(0, 3, "skew_rd");
    endtask

    task automatic test_error_hold;
        rresp_cfg = 2'b10;
        issue(1'b0, 10'h028, 32'h0);
        collect(4, 3, "rderr");
        rresp_cfg = 2'b00;
        bresp_cfg = 2'b10;
        issue(1'b1, 10'h02c, 32'hCAFE_0001);
        collect(0, 3, "wrerr");
        bresp_cfg = 2'b00;
    endtask

    task automatic test_reset_mid_read;
        r_delay = 8;
        issue(1'b0, 10'h024, 32'h0);
        repeat (2) @(negedge aclk);
        total++;
        if (m_axi_rready !== 1'b1) begin bad++; $display("FAIL rst_in_rd_resp rready=%b want=1", m_axi_rready); end
        #2 aresetn = 0;
        #1;
        total++;
        if ({cmd_ready_o, resp_v_o, m_axi_arvalid, m_axi_rready, m_axi_bready} !== 5'b10000) begin
            bad++; $display("FAIL rst_async got=%b want=10000",
                            {cmd_ready_o, resp_v_o, m_axi_arvalid, m_axi_rready, m_axi_bready});
        end
        sb.delete();
        repeat (2) @(negedge aclk);
        #2 aresetn = 1;
        r_delay = 0;
        @(negedge aclk);
        total++;
        if (resp_v_o !== 1'b0) begin bad++; $display("FAIL rst_no_resp resp_v=%b want=0", resp_v_o); end
        issue(1'b0, 10'h010, 32'h0);
        collect(0, 3, "post_rst");
    endtask

    task automatic test_back_to_back;
        logic [9:0] a;
        int p0 = proto_err;
        int b0 = b_n;
        for (int i = 0; i < 8; i++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            b_delay  = $urandom_range(0, 3); ar_delay = $urandom_range(0, 3);
            r_delay  = $urandom_range(0, 3);
            a = 10'($urandom_range(64, 127) * 4);
            issue(1'b1, a, $urandom);
            collect(0, -1, "b2b_wr");
            issue(1'b0, a, 32'h0);
            collect(0, -1, "b2b_rd");
        end
        aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
        total++;
        if (b_n - b0 != 8) begin bad++; $display("FAIL b2b_writes got=%0d want=8", b_n - b0); end
        total++;
        if (proto_err != p0) begin bad++; $display("FAIL b2b_protocol got=%0d want=%0d", proto_err, p0); end
    endtask

    task automatic test_watchdog;
        logic want_to;
`ifdef EXAMPLE_AXIL_MASTER_WATCHDOG_EN
        want_to = 1'b1;
`else
        want_to = 1'b0;
`endif
        b_hold = 1;
        issue(1'b1, 10'h030, 32'h5555_AAAA);
        repeat (9) @(negedge aclk);
        total++;
        if (timeout_o !== 1'b0) begin bad++; $display("FAIL wd_early got=%b want=0", timeout_o); end
        repeat (10) @(negedge aclk);
        total++;
        if (timeout_o !== want_to) begin bad++; $display("FAIL wd_set got=%b want=%b", timeout_o, want_to); end
        b_hold = 0;
        collect(0, -1, "wd_wr");
        total++;
        if (timeout_o !== want_to) begin bad++; $display("FAIL wd_sticky got=%b want=%b", timeout_o, want_to); end
    endtask

    initial begin
        aresetn = 0; cmd_v = 0; cmd_we = 0; cmd_addr = 0; cmd_data = 0; resp_yumi = 0;
        for (int i = 0; i < 256; i++) begin
            smem[i]    = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        test_reset;
        test_write_zero_wait;
        test_read_back;
        test_write_skew;
        test_error_hold;
        test_reset_mid_read;
        test_back_to_back;
        test_watchdog;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t limit=500000", $time);
        $fatal(1);
    end

endmodule
